// File: rtl/mram_pkg.sv
// mram_pkg: shared state encoding, default widths and timing for the MRAM access controller.
package mram_pkg;
   typedef enum logic [2:0] {IDLE, SETUP, WPULSE, WHOLD, RWAIT, TURN} state_t;
   localparam int DEF_ADDR_W = 20;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_T_AS   = 1;
   localparam int DEF_T_WP   = 4;
   localparam int DEF_T_WH   = 1;
   localparam int DEF_T_RD   = 4;
   localparam int DEF_T_TURN = 1;
   localparam logic STROBE_OFF = 1'b1;
   function automatic int max_of(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/mram_wait_cnt.sv
// mram_wait_cnt: loadable down-counter that parks at zero and flags done there.
module mram_wait_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);
   logic [W-1:0] cnt_q, cnt_d;
   assign done = cnt_q == '0;
   always_comb cnt_d = load ? load_val : (done ? cnt_q : cnt_q - 1'b1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mram_access_ctrl.sv
// mram_access_ctrl: turns one parallel request into a timed asynchronous MRAM access.
// Every pin is a flop fed from the next-state decode, so strobes never glitch.
module mram_access_ctrl
   import mram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int T_AS   = DEF_T_AS,
   parameter int T_WP   = DEF_T_WP,
   parameter int T_WH   = DEF_T_WH,
   parameter int T_RD   = DEF_T_RD,
   parameter int T_TURN = DEF_T_TURN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_be,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] mram_addr,
   output logic [DATA_W-1:0] mram_dq_out,
   output logic              mram_dq_oe,
   input  logic [DATA_W-1:0] mram_dq_in,
   output logic              chip_en,
   output logic              write_en,
   output logic              out_en,
   output logic              lower_byte_en,
   output logic              upper_byte_en
);
   localparam int T_MAX = max_of(max_of(max_of(T_AS, T_WP), max_of(T_WH, T_RD)), T_TURN);
   localparam int CNT_W = $clog2(T_MAX + 1);
   localparam logic [CNT_W-1:0] LV_AS   = CNT_W'(T_AS - 1);
   localparam logic [CNT_W-1:0] LV_WP   = CNT_W'(T_WP - 1);
   localparam logic [CNT_W-1:0] LV_WH   = CNT_W'(T_WH - 1);
   localparam logic [CNT_W-1:0] LV_RD   = CNT_W'(T_RD - 1);
   localparam logic [CNT_W-1:0] LV_TURN = CNT_W'(T_TURN - 1);

   if (T_AS < 1 || T_WP < 1 || T_WH < 1 || T_RD < 1 || T_TURN < 1) begin : g_bad_timing
      $error("mram_access_ctrl: every timing parameter must be at least 1");
   end

   state_t state_q, state_d;
   logic wr_q, wr_d, done, load, acc;
   logic [1:0] be_q, be_d;
   logic [CNT_W-1:0] load_val;
   logic [ADDR_W-1:0] mram_addr_q, mram_addr_d;
   logic [DATA_W-1:0] mram_dq_out_q, mram_dq_out_d, rd_data_q, rd_data_d;
   logic req_ready_q, req_ready_d, rd_valid_q, rd_valid_d, mram_dq_oe_q, mram_dq_oe_d;
   logic chip_en_q, chip_en_d, write_en_q, write_en_d, out_en_q, out_en_d;
   logic lower_byte_en_q, lower_byte_en_d, upper_byte_en_q, upper_byte_en_d;

   mram_wait_cnt #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .done(done)
   );

   always_comb begin
      state_d = state_q;
      wr_d = wr_q;
      be_d = be_q;
      mram_addr_d = mram_addr_q;
      mram_dq_out_d = mram_dq_out_q;
      load = 1'b0;
      load_val = '0;
      case (state_q)
         IDLE: if (req_valid) begin
            wr_d = req_write;
            be_d = req_be;
            mram_addr_d = req_addr;
            mram_dq_out_d = req_wdata;
            load = 1'b1;
            // A write with no byte enabled touches nothing; just burn the turnaround.
            state_d = (req_write && req_be == 2'b00) ? TURN : SETUP;
            load_val = (req_write && req_be == 2'b00) ? LV_TURN : LV_AS;
         end
         SETUP: if (done) begin
            load = 1'b1;
            state_d = wr_q ? WPULSE : RWAIT;
            load_val = wr_q ? LV_WP : LV_RD;
         end
         WPULSE: if (done) begin
            load = 1'b1;
            state_d = WHOLD;
            load_val = LV_WH;
         end
         WHOLD, RWAIT: if (done) begin
            load = 1'b1;
            state_d = TURN;
            load_val = LV_TURN;
         end
         TURN: if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      acc = state_d inside {SETUP, WPULSE, WHOLD, RWAIT};
      req_ready_d = state_d == IDLE;
      chip_en_d = acc ? 1'b0 : STROBE_OFF;
      write_en_d = state_d == WPULSE ? 1'b0 : STROBE_OFF;
      out_en_d = state_d == RWAIT ? 1'b0 : STROBE_OFF;
      mram_dq_oe_d = acc && wr_d;
      lower_byte_en_d = acc ? (wr_d ? ~be_d[0] : 1'b0) : STROBE_OFF;
      upper_byte_en_d = acc ? (wr_d ? ~be_d[1] : 1'b0) : STROBE_OFF;
      rd_valid_d = state_q == RWAIT && state_d == TURN;
      rd_data_d = rd_valid_d ? mram_dq_in : rd_data_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         wr_q <= 1'b0;
         be_q <= '0;
         mram_addr_q <= '0;
         mram_dq_out_q <= '0;
         rd_data_q <= '0;
         req_ready_q <= 1'b1;
         rd_valid_q <= 1'b0;
         mram_dq_oe_q <= 1'b0;
         chip_en_q <= STROBE_OFF;
         write_en_q <= STROBE_OFF;
         out_en_q <= STROBE_OFF;
         lower_byte_en_q <= STROBE_OFF;
         upper_byte_en_q <= STROBE_OFF;
      end else begin
         state_q <= state_d;
         wr_q <= wr_d;
         be_q <= be_d;
         mram_addr_q <= mram_addr_d;
         mram_dq_out_q <= mram_dq_out_d;
         rd_data_q <= rd_data_d;
         req_ready_q <= req_ready_d;
         rd_valid_q <= rd_valid_d;
         mram_dq_oe_q <= mram_dq_oe_d;
         chip_en_q <= chip_en_d;
         write_en_q <= write_en_d;
         out_en_q <= out_en_d;
         lower_byte_en_q <= lower_byte_en_d;
         upper_byte_en_q <= upper_byte_en_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rd_valid = rd_valid_q;
   assign rd_data = rd_data_q;
   assign mram_addr = mram_addr_q;
   assign mram_dq_out = mram_dq_out_q;
   assign mram_dq_oe = mram_dq_oe_q;
   assign chip_en = chip_en_q;
   assign write_en = write_en_q;
   assign out_en = out_en_q;
   assign lower_byte_en = lower_byte_en_q;
   assign upper_byte_en = upper_byte_en_q;
endmodule

// File: tb/tb_mram_access_ctrl.sv
// tb_mram_access_ctrl: timeline model of each access plus a pin-level MRAM, checked every cycle.
module tb_mram_access_ctrl;
   localparam int T_AS = 1, T_WP = 4, T_WH = 1, T_RD = 4, T_TURN = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic req_valid = 1'b0, req_write = 1'b0;
   logic [19:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [1:0] req_be = '0;
   logic req_ready, rd_valid, mram_dq_oe;
   logic [15:0] rd_data, mram_dq_out;
   logic [15:0] mram_dq_in = '0;
   logic [19:0] mram_addr;
   logic chip_en, write_en, out_en, lower_byte_en, upper_byte_en;

   mram_access_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rd_valid(rd_valid), .rd_data(rd_data), .mram_addr(mram_addr),
      .mram_dq_out(mram_dq_out), .mram_dq_oe(mram_dq_oe), .mram_dq_in(mram_dq_in),
      .chip_en(chip_en), .write_en(write_en), .out_en(out_en),
      .lower_byte_en(lower_byte_en), .upper_byte_en(upper_byte_en)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0, acc_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at cyc %0d", nm, got, exp, cyc);
      end
   endtask

   // Unwritten locations read back as the inverted low address bits.
   logic [15:0] pin_mem [int];
   logic [15:0] mm [int];
   function automatic logic [15:0] pin_rd(input logic [19:0] a);
      return pin_mem.exists(int'(a)) ? pin_mem[int'(a)] : ~a[15:0];
   endfunction
   function automatic logic [15:0] mm_rd(input logic [19:0] a);
      return mm.exists(int'(a)) ? mm[int'(a)] : ~a[15:0];
   endfunction

   always @(posedge write_en) if (rst && !chip_en) begin : pin_write
      logic [15:0] v;
      v = pin_rd(mram_addr);
      if (!lower_byte_en) v[7:0] = mram_dq_out[7:0];
      if (!upper_byte_en) v[15:8] = mram_dq_out[15:8];
      pin_mem[int'(mram_addr)] = v;
   end

   always @(negedge clk) mram_dq_in <= (!chip_en && !out_en) ? pin_rd(mram_addr) : 16'h0000;

   always @(posedge clk) cyc++;

   // Model: m_c counts cycles since the accept edge; access spans 1..m_end, turnaround follows.
   bit m_busy = 0, m_wr = 0;
   int m_c = 0, m_end = 0, m_len = 0;
   logic [19:0] m_a = '0;
   logic [15:0] m_d = '0, m_rdata = '0, m_v = '0;
   logic [1:0] m_be = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy = 0;
         m_c = 0;
         m_rdata = '0;
      end else if (m_busy) begin
         m_c++;
         if (m_wr && m_end > 0 && m_c == m_end + 1) begin
            m_v = mm_rd(m_a);
            if (m_be[0]) m_v[7:0] = m_d[7:0];
            if (m_be[1]) m_v[15:8] = m_d[15:8];
            mm[int'(m_a)] = m_v;
         end
         if (!m_wr && m_c == m_end + 1) m_rdata = mm_rd(m_a);
         if (m_c > m_len) m_busy = 0;
      end else if (req_valid) begin
         m_busy = 1;
         m_c = 1;
         m_wr = req_write;
         m_a = req_addr;
         m_d = req_wdata;
         m_be = req_be;
         m_end = (req_write && req_be == 2'b00) ? 0 : req_write ? T_AS + T_WP + T_WH : T_AS + T_RD;
         m_len = m_end + T_TURN;
      end
   end

   always @(negedge clk) begin : cmp
      bit acc;
      acc = m_busy && m_c <= m_end;
      chk("req_ready", req_ready, !m_busy);
      chk("chip_en", chip_en, !acc);
      chk("write_en", write_en, !(acc && m_wr && m_c > T_AS && m_c <= T_AS + T_WP));
      chk("out_en", out_en, !(acc && !m_wr && m_c > T_AS));
      chk("dq_oe", mram_dq_oe, acc && m_wr);
      chk("lower_byte_en", lower_byte_en, !(acc && (!m_wr || m_be[0])));
      chk("upper_byte_en", upper_byte_en, !(acc && (!m_wr || m_be[1])));
      chk("rd_valid", rd_valid, m_busy && !m_wr && m_c == m_end + 1);
      chk("rd_data", rd_data, m_rdata);
      chk("no_contention", mram_dq_oe && !out_en, 0);
      if (acc) chk("mram_addr", mram_addr, m_a);
      if (acc && m_wr) chk("dq_out", mram_dq_out, m_d);
   end

   int cnt_ce, cnt_we, cnt_oe, cnt_nr, cnt_rdv, cnt_dqoe, dq_nf, cnt_lbe, cnt_ube, ce_f, we_f, rdv_f;
   int falls[$], rises[$];
   bit ce_prev = 1;

   task automatic clr();
      {cnt_ce, cnt_we, cnt_oe, cnt_nr, cnt_rdv, cnt_dqoe, dq_nf, cnt_lbe, cnt_ube} = '0;
      ce_f = -1;
      we_f = -1;
      rdv_f = -1;
      falls.delete();
      rises.delete();
   endtask

   always @(negedge clk) begin
      if (!chip_en) begin cnt_ce++; if (ce_f < 0) ce_f = cyc; end
      if (!write_en) begin cnt_we++; if (we_f < 0) we_f = cyc; end
      if (!out_en) cnt_oe++;
      if (!req_ready) cnt_nr++;
      if (rd_valid) begin cnt_rdv++; if (rdv_f < 0) rdv_f = cyc; end
      if (mram_dq_oe) begin cnt_dqoe++; if (mram_dq_out != 16'hFFFF) dq_nf++; end
      if (!lower_byte_en) cnt_lbe++;
      if (!upper_byte_en) cnt_ube++;
      if (!chip_en && ce_prev) falls.push_back(cyc);
      if (chip_en && !ce_prev) rises.push_back(cyc);
      ce_prev = chip_en;
   end

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      chk("accept_in_time", n < 50, 1);
      acc_cyc = cyc + 1;
   endtask

   task automatic send(input bit w, input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
      @(posedge clk); #1;
      clr();
      @(negedge clk);
      req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      wait_ready();
      @(posedge clk); #1;
      req_valid = 0; req_write = 1'($urandom); req_addr = 20'($urandom);
      req_wdata = 16'($urandom); req_be = 2'($urandom);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      clr();
      repeat (4) begin
         @(negedge clk);
         req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = 20'($urandom);
         req_wdata = 16'($urandom); req_be = 2'($urandom);
         #1;
         chk("rst_strobes", {chip_en, write_en, out_en, lower_byte_en, upper_byte_en}, 5'b11111);
         chk("rst_dq_oe", mram_dq_oe, 0);
         chk("rst_ready", req_ready, 1);
         chk("rst_rd_valid", rd_valid, 0);
      end
      @(negedge clk);
      req_valid = 0;
      rst = 1;

      send(1, 20'h003FF, 16'hFFFF, 2'b11);
      settle(10);
      chk("wr_ce_cycles", cnt_ce, 6);
      chk("wr_we_cycles", cnt_we, 4);
      chk("wr_ce_first", ce_f - acc_cyc, 0);
      chk("wr_we_after_ce", we_f - ce_f, 1);
      chk("wr_ready_low", cnt_nr, 7);
      chk("wr_dq_oe_cycles", cnt_dqoe, 6);
      chk("wr_dq_ffff", dq_nf, 0);

      send(0, 20'hAAAAA, 16'h0000, 2'b00);
      settle(10);
      chk("rd_oe_cycles", cnt_oe, 4);
      chk("rd_valid_latency", rdv_f - acc_cyc, 5);
      chk("rd_valid_pulses", cnt_rdv, 1);
      chk("rd_data_5555", rd_data, 16'h5555);
      chk("rd_no_dq_oe", cnt_dqoe, 0);
      chk("rd_ready_low", cnt_nr, 6);

      send(0, 20'h003FF, 16'h0000, 2'b11);
      settle(10);
      chk("rd_back_ffff", rd_data, 16'hFFFF);

      send(1, 20'h00100, 16'h1234, 2'b01);
      settle(10);
      chk("be01_lower", cnt_lbe, 6);
      chk("be01_upper", cnt_ube, 0);
      send(0, 20'h00100, 16'h0000, 2'b00);
      settle(10);
      chk("be01_readback", rd_data, 16'hFE34);

      send(1, 20'h00180, 16'h7777, 2'b00);
      settle(6);
      chk("nop_ready_low", cnt_nr, 1);
      chk("nop_no_ce", cnt_ce, 0);
      chk("nop_no_we", cnt_we, 0);

      @(posedge clk); #1;
      clr();
      @(negedge clk);
      req_valid = 1; req_write = 1; req_addr = 20'h00300; req_wdata = 16'hA5C3; req_be = 2'b11;
      wait_ready();
      @(posedge clk); #1;
      req_write = 0;
      @(negedge clk);
      wait_ready();
      @(posedge clk); #1;
      req_valid = 0;
      settle(10);
      chk("b2b_accesses", falls.size() >= 2 && rises.size() >= 1, 1);
      chk("b2b_gap_ge1", (falls.size() >= 2 && rises.size() >= 1) ? (falls[1] - rises[0] >= 1) : 0, 1);
      chk("b2b_readback", rd_data, 16'hA5C3);

      send(1, 20'h00200, 16'hBEEF, 2'b11);
      begin
         int n = 0;
         while (write_en && n < 20) begin @(negedge clk); n++; end
      end
      chk("wpulse_reached", write_en, 0);
      #1 rst = 0;
      #1;
      chk("arst_write_en", write_en, 1);
      chk("arst_chip_en", chip_en, 1);
      chk("arst_dq_oe", mram_dq_oe, 0);
      @(negedge clk);
      rst = 1;
      clr();
      settle(10);
      chk("arst_ready", req_ready, 1);
      chk("arst_no_rd_valid", cnt_rdv, 0);
      chk("arst_idle_ce", cnt_ce, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
